// File: rtl/pe_pkg.sv
// Shared PE definitions: weight-path geometry, kernel mode encodings,
// loader state encoding and the mode-to-row-count helper.
package pe_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int ROW_NUM        = 6;
    localparam int ROW_DATA_WIDTH = DATA_WIDTH * ROW_NUM;
    localparam int ADDR_WIDTH     = 10;
    localparam int BIAS_WIDTH     = 2 * DATA_WIDTH;
    localparam int CNT_WIDTH      = $clog2(ROW_NUM + 1);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    typedef enum logic [1:0] {
        MODE_2x3x3 = 2'b00,
        MODE_4x4   = 2'b01,
        MODE_5x5   = 2'b10,
        MODE_6x6   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LAST,
        ST_CLEAR,
        ST_DONE
    } state_e;

    // Number of weight rows a kernel mode occupies. The dual 3x3 mode
    // packs both kernels side by side in the same three rows.
    function automatic cnt_t rows_for_mode(input logic [1:0] mode);
        case (mode)
            MODE_2x3x3: return cnt_t'(3);
            MODE_4x4:   return cnt_t'(4);
            MODE_5x5:   return cnt_t'(5);
            default:    return cnt_t'(ROW_NUM);
        endcase
    endfunction

endpackage

// File: rtl/wgt_loader.sv
// Weight loader: fetches K kernel rows from weight memory, writes them one
// per cycle into the PE weight register file, zeroes the unused rows,
// captures the kernel bias and signals done.
module wgt_loader
    import pe_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [1:0]                i_mode,
    input  logic [ADDR_WIDTH-1:0]     i_base_addr,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_rd_en,
    output logic [ADDR_WIDTH-1:0]     o_rd_addr,
    input  logic [ROW_DATA_WIDTH-1:0] i_rd_data,
    input  logic [BIAS_WIDTH-1:0]     i_bias,
    output logic [ROW_NUM-1:0]        o_wr_en,
    output logic [ROW_DATA_WIDTH-1:0] o_wgt_row,
    output logic [BIAS_WIDTH-1:0]     o_bias
);

    state_e                state;
    cnt_t                  k_q;      // rows in the kernel being loaded
    cnt_t                  rd_cnt;   // reads issued so far
    cnt_t                  wr_cnt;   // rows written so far
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  rd_vld;   // i_rd_data holds a requested row this cycle
    logic                  start_ok;

    // A start only counts when no load is in flight; it is never queued.
    assign start_ok = i_start && (state == ST_IDLE || state == ST_DONE);

    // Sequencer: read issue, state progression and registered status outputs.
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            k_q       <= '0;
            rd_cnt    <= '0;
            base_q    <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_rd_en   <= 1'b0;
            o_rd_addr <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        k_q       <= rows_for_mode(i_mode);
                        base_q    <= i_base_addr;
                        rd_cnt    <= cnt_t'(1);
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= i_base_addr;
                        o_busy    <= 1'b1;
                        state     <= ST_FETCH;
                    end else begin
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (rd_cnt == k_q) begin
                        o_rd_en <= 1'b0;
                        state   <= ST_LAST;
                    end else begin
                        // Address arithmetic wraps at the top of weight memory.
                        o_rd_addr <= base_q + ADDR_WIDTH'(rd_cnt);
                        rd_cnt    <= rd_cnt + 1'b1;
                    end
                end
                ST_LAST: begin
                    if (k_q < cnt_t'(ROW_NUM)) begin
                        state <= ST_CLEAR;
                    end else begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_CLEAR: begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    state  <= ST_DONE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Write-side bookkeeping: read-data valid, row counter and bias capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_vld <= 1'b0;
            wr_cnt <= '0;
            o_bias <= '0;
        end else begin
            rd_vld <= o_rd_en;
            if (start_ok) begin
                wr_cnt <= '0;
            end else if (rd_vld) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            // The bias travels with kernel row 0 only.
            if (rd_vld && wr_cnt == '0) begin
                o_bias <= i_bias;
            end
        end
    end

    // Register-file write port: one row per returned read, then a single
    // broadcast clear of every row the kernel does not use.
    // NOTE: both outputs get a default before any branch so no path leaves
    // them unassigned, which would otherwise infer a latch.
    always_comb begin
        o_wr_en   = '0;
        o_wgt_row = '0;
        if (rd_vld) begin
            o_wr_en   = ROW_NUM'(1) << wr_cnt;
            o_wgt_row = i_rd_data;
        end else if (state == ST_CLEAR) begin
            for (int i = 0; i < ROW_NUM; i++) begin
                o_wr_en[i] = (cnt_t'(i) >= k_q);
            end
        end
    end

endmodule
